// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event generator.
// Define KEY_AUTOREPEAT_EN to make a long-held key emit periodic press pulses.
package key_event_pkg;

  localparam int NUM_KEYS = 4;
  localparam int CNT_W    = 16;

  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_DEB_MS    = 20;
  localparam int DEF_LONG_MS   = 1000;
  localparam int DEF_REPEAT_MS = 200;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_DEB_PRESS   = 3'd1;
  localparam state_t ST_HELD        = 3'd2;
  localparam state_t ST_LONG        = 3'd3;
  localparam state_t ST_DEB_RELEASE = 3'd4;

endpackage

// File: rtl/key_event_ch.sv
// One key channel: input synchronizer plus debounce / long-press / release FSM.
// Auto-repeat in the LONG state follows the KEY_AUTOREPEAT_EN build option.
module key_event_ch
  import key_event_pkg::*;
#(
  parameter int DEB_MS    = DEF_DEB_MS,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_in,
  output logic sw_out,
  output logic press_pulse,
  output logic long_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_MS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  logic             sync_1;
  logic             sync_2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             origin_long;

  // NOTE: every register here is a flop with a reset value; non-blocking
  // assignments keep the synchronizer stages and FSM updating in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1        <= 1'b0;
      sync_2        <= 1'b0;
      state         <= ST_IDLE;
      cnt           <= '0;
      origin_long   <= 1'b0;
      sw_out        <= 1'b0;
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_1        <= sw_in;
      sync_2        <= sync_1;
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;

      // A level change always wins over a tick in the same cycle.
      case (state)
        ST_IDLE: begin
          if (sync_2) begin
            state <= ST_DEB_PRESS;
            cnt   <= '0;
          end
        end
        ST_DEB_PRESS: begin
          if (!sync_2) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (cnt == DEB_LAST) begin
              state       <= ST_HELD;
              sw_out      <= 1'b1;
              press_pulse <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (!sync_2) begin
            state       <= ST_DEB_RELEASE;
            cnt         <= '0;
            origin_long <= 1'b0;
          end else if (tick) begin
            if (cnt == LONG_LAST) begin
              state      <= ST_LONG;
              long_pulse <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (!sync_2) begin
            state       <= ST_DEB_RELEASE;
            cnt         <= '0;
            origin_long <= 1'b1;
          end else if (tick && AUTOREPEAT) begin
            if (cnt == REPEAT_LAST) begin
              press_pulse <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DEB_RELEASE: begin
          if (sync_2) begin
            state <= origin_long ? ST_LONG : ST_HELD;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == DEB_LAST) begin
              state         <= ST_IDLE;
              sw_out        <= 1'b0;
              release_pulse <= 1'b1;
              cnt           <= '0;
              origin_long   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Four-key debouncer with press, long-press and release event pulses.
// Build option KEY_AUTOREPEAT_EN enables auto-repeat press pulses while held long.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int DEB_MS    = DEF_DEB_MS,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] sw_in,
  output logic [NUM_KEYS-1:0] sw_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = (pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_event_ch #(
      .DEB_MS    (DEB_MS),
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .sw_in         (sw_in[i]),
      .sw_out        (sw_out[i]),
      .press_pulse   (press_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: directed scenarios plus random key activity, checked
// every cycle against an event model built on stable-level run lengths in ticks.
module tb_key_event_gen;

  localparam int TICK_DIV  = 4;
  localparam int DEB_MS    = 3;
  localparam int LONG_MS   = 10;
  localparam int REPEAT_MS = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_in = '0;
  logic [3:0] sw_out, press_pulse, long_pulse, release_pulse;

  key_event_gen #(
    .TICK_DIV  (TICK_DIV),
    .DEB_MS    (DEB_MS),
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_in         (sw_in),
    .sw_out        (sw_out),
    .press_pulse   (press_pulse),
    .long_pulse    (long_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a key event is decided by how many ticks the synchronized
  // level has stayed unchanged (run) and by where the current timing window began (base).
  logic [3:0] m_q1 = '0, m_q2 = '0, m_prev = '0, m_down = '0, m_long = '0;
  int         m_pre = 0;
  int         m_run[4]  = '{0, 0, 0, 0};
  int         m_base[4] = '{0, 0, 0, 0};
  logic [3:0] exp_out = '0, exp_press = '0, exp_long = '0, exp_rel = '0;

  task automatic model_reset();
    m_q1 = '0; m_q2 = '0; m_prev = '0; m_down = '0; m_long = '0; m_pre = 0;
    for (int c = 0; c < 4; c++) begin
      m_run[c]  = 0;
      m_base[c] = 0;
    end
    exp_out = '0; exp_press = '0; exp_long = '0; exp_rel = '0;
  endtask

  task automatic model_step();
    bit tk;
    bit s;
    tk = (m_pre == TICK_DIV - 1);
    exp_press = '0; exp_long = '0; exp_rel = '0;
    for (int c = 0; c < 4; c++) begin
      s = m_q2[c];
      if (s != m_prev[c]) begin
        m_run[c] = 0;
        if (s && m_down[c]) m_base[c] = 0;
      end else if (tk) begin
        m_run[c]++;
        if (!m_down[c]) begin
          if (s && m_run[c] == DEB_MS) begin
            exp_press[c] = 1'b1; m_down[c] = 1'b1; m_base[c] = DEB_MS;
          end
        end else if (!s) begin
          if (m_run[c] == DEB_MS) begin
            exp_rel[c] = 1'b1; m_down[c] = 1'b0; m_long[c] = 1'b0;
          end
        end else if (!m_long[c]) begin
          if (m_run[c] - m_base[c] == LONG_MS) begin
            exp_long[c] = 1'b1; m_long[c] = 1'b1; m_base[c] = m_run[c];
          end
        end else if (REPEAT_ON && (m_run[c] - m_base[c] == REPEAT_MS)) begin
          exp_press[c] = 1'b1; m_base[c] = m_run[c];
        end
      end
      m_prev[c] = s;
    end
    exp_out = m_down;
    m_q2  = m_q1;
    m_q1  = sw_in;
    m_pre = (m_pre == TICK_DIV - 1) ? 0 : m_pre + 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle comparison and event tallies for the directed scenarios.
  bit mon_en = 1'b0;
  int cnt_press[4], cnt_long[4], cnt_rel[4], cnt_high[4];
  int both_press = 0;

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      cnt_press[c] = 0; cnt_long[c] = 0; cnt_rel[c] = 0; cnt_high[c] = 0;
    end
    both_press = 0;
  endtask

  task automatic monitor_step();
    check("sw_out", 32'(sw_out), 32'(exp_out));
    check("press_pulse", 32'(press_pulse), 32'(exp_press));
    check("long_pulse", 32'(long_pulse), 32'(exp_long));
    check("release_pulse", 32'(release_pulse), 32'(exp_rel));
    for (int c = 0; c < 4; c++) begin
      cnt_press[c] += int'(press_pulse[c]);
      cnt_long[c]  += int'(long_pulse[c]);
      cnt_rel[c]   += int'(release_pulse[c]);
      cnt_high[c]  += int'(sw_out[c]);
    end
    if (press_pulse[1:0] == 2'b11) both_press++;
  endtask

  always @(negedge clk) begin
    if (mon_en) monitor_step();
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    cycles(n * TICK_DIV);
  endtask

  int hold_left[4] = '{0, 0, 0, 0};

  initial begin
    clear_counts();
    cycles(3);
    rst = 1'b0;
    mon_en = 1'b1;

    // Clean press and release on key 0.
    clear_counts();
    sw_in[0] = 1'b1;
    ticks(8);
    check("k0_sw_out_held", 32'(sw_out[0]), 32'd1);
    sw_in[0] = 1'b0;
    ticks(6);
    check("k0_press_count", cnt_press[0], 1);
    check("k0_release_count", cnt_rel[0], 1);

    // Bouncing key 1 never qualifies.
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      sw_in[1] = 1'b1; ticks(2);
      sw_in[1] = 1'b0; ticks(2);
    end
    ticks(6);
    check("k1_bounce_press", cnt_press[1], 0);
    check("k1_bounce_high", cnt_high[1], 0);

    // Long hold on key 2.
    clear_counts();
    sw_in[2] = 1'b1;
    ticks(27);
    sw_in[2] = 1'b0;
    ticks(6);
    check("k2_long_count", cnt_long[2], 1);
    check("k2_press_count", cnt_press[2], REPEAT_ON ? 4 : 1);
    check("k2_release_count", cnt_rel[2], 1);

    // Simultaneous press on keys 0 and 1.
    clear_counts();
    sw_in[1:0] = 2'b11;
    ticks(6);
    check("k01_same_cycle", both_press, 1);
    sw_in[1:0] = 2'b00;
    ticks(6);

    // Reset while key 3 is held.
    sw_in[3] = 1'b1;
    ticks(6);
    check("k3_held_before_rst", 32'(sw_out[3]), 32'd1);
    clear_counts();
    rst = 1'b1;
    #1;
    check("rst_outputs_zero", {sw_out, press_pulse, long_pulse, release_pulse}, 32'h0);
    cycles(2);
    check("rst_outputs_hold", {sw_out, press_pulse, long_pulse, release_pulse}, 32'h0);
    rst = 1'b0;
    ticks(6);
    check("k3_fresh_press", cnt_press[3], 1);
    check("k3_no_release", cnt_rel[3], 0);
    sw_in[3] = 1'b0;
    ticks(6);

    // Random activity: mixes of bounces, short and long holds, occasional resets.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold_left[c] == 0) begin
          sw_in[c] = 1'($urandom_range(0, 1));
          hold_left[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(40, 120))
                                                     : int'($urandom_range(1, 20));
        end else begin
          hold_left[c]--;
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        cycles(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
      cycles(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
